// File: rtl/neat_pkg.sv
// Shared constants for the gene stream: lane phase codes, default widths and the
// streamer FSM encoding.
package neat_pkg;

  localparam int unsigned GENE_SZ_DEF = 64;
  localparam int unsigned ATTR_SZ_DEF = 8;
  localparam int unsigned ADDR_SZ_DEF = 8;

  localparam logic [1:0] ST_NODE = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_CONN = 2'b10;
  localparam logic [1:0] ST_END  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StNode,
    StConn,
    StEnd
  } streamer_fsm_e;

  // Node and conn phases are the only codes that carry a real gene.
  function automatic logic is_gene_phase(input logic [1:0] ph);
    return ~ph[0];
  endfunction

endpackage

// File: rtl/streamer_addr_ctr.sv
// Genome memory read address plus remaining-read down-counter for the current phase.
module streamer_addr_ctr import neat_pkg::*; #(
  parameter int unsigned ADDR_SZ = ADDR_SZ_DEF,
  parameter int unsigned ATTR_SZ = ATTR_SZ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               addr_load,
  input  logic [ADDR_SZ-1:0] addr_val,
  input  logic               cnt_load,
  input  logic [ATTR_SZ-1:0] cnt_val,
  input  logic               step,
  output logic [ADDR_SZ-1:0] addr,
  output logic               last
);

  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [ATTR_SZ-1:0] cnt_q, cnt_d;

  // A count load wins over a step so a phase change can reload while the address advances.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (addr_load) begin
      addr_d = addr_val;
    end else if (step) begin
      addr_d = addr_q + ADDR_SZ'(1);
    end
    if (cnt_load) begin
      cnt_d = cnt_val;
    end else if (step) begin
      cnt_d = cnt_q - ATTR_SZ'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == ATTR_SZ'(1));

endmodule

// File: rtl/genome_streamer.sv
// Streams one genome (node genes then conn genes) from a synchronous-read memory,
// one gene per cycle, with the lane phase code aligned to the read data.
module genome_streamer import neat_pkg::*; #(
  parameter int unsigned GENE_SZ = GENE_SZ_DEF,
  parameter int unsigned ATTR_SZ = ATTR_SZ_DEF,
  parameter int unsigned ADDR_SZ = ADDR_SZ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_SZ-1:0] base_addr,
  input  logic [ATTR_SZ-1:0] num_nodes,
  input  logic [ATTR_SZ-1:0] num_conns,
  input  logic               hold,
  output logic               mem_rd_en,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [GENE_SZ-1:0] mem_rd_data,
  output logic [GENE_SZ-1:0] gene_out,
  output logic [1:0]         state,
  output logic               busy
);

  streamer_fsm_e fsm_q, fsm_d;

  logic [ATTR_SZ-1:0] conns_q, conns_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_SZ-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]         tag_q, tag_d;
  logic [1:0]         phase_q, phase_d;

  logic               ctr_addr_load;
  logic [ADDR_SZ-1:0] ctr_addr_val;
  logic               ctr_cnt_load;
  logic [ATTR_SZ-1:0] ctr_cnt_val;
  logic               ctr_step;
  logic [ADDR_SZ-1:0] ctr_addr;
  logic               ctr_last;

  streamer_addr_ctr #(
    .ADDR_SZ(ADDR_SZ),
    .ATTR_SZ(ATTR_SZ)
  ) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .addr_load(ctr_addr_load),
    .addr_val (ctr_addr_val),
    .cnt_load (ctr_cnt_load),
    .cnt_val  (ctr_cnt_val),
    .step     (ctr_step),
    .addr     (ctr_addr),
    .last     (ctr_last)
  );

  // The start cycle issues the first read directly so it is on the bus the next cycle;
  // the counter then holds the address and count of the reads still to come.
  always_comb begin
    fsm_d         = fsm_q;
    conns_d       = conns_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    tag_d         = tag_q;
    ctr_addr_load = 1'b0;
    ctr_addr_val  = base_addr + ADDR_SZ'(1);
    ctr_cnt_load  = 1'b0;
    ctr_cnt_val   = '0;
    ctr_step      = 1'b0;
    phase_d       = rd_en_q ? tag_q : ST_IDLE;

    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          conns_d       = num_conns;
          ctr_addr_load = 1'b1;
          if (num_nodes != '0) begin
            rd_en_d      = 1'b1;
            rd_addr_d    = base_addr;
            tag_d        = ST_NODE;
            ctr_cnt_load = 1'b1;
            if (num_nodes == ATTR_SZ'(1)) begin
              ctr_cnt_val = num_conns;
              fsm_d       = (num_conns != '0) ? StConn : StEnd;
            end else begin
              ctr_cnt_val = num_nodes - ATTR_SZ'(1);
              fsm_d       = StNode;
            end
          end else if (num_conns != '0) begin
            rd_en_d      = 1'b1;
            rd_addr_d    = base_addr;
            tag_d        = ST_CONN;
            ctr_cnt_load = 1'b1;
            ctr_cnt_val  = num_conns - ATTR_SZ'(1);
            fsm_d        = (num_conns == ATTR_SZ'(1)) ? StEnd : StConn;
          end else begin
            fsm_d = StEnd;
          end
        end
      end
      StNode, StConn: begin
        if (!hold) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ctr_addr;
          tag_d     = (fsm_q == StNode) ? ST_NODE : ST_CONN;
          ctr_step  = 1'b1;
          if (ctr_last) begin
            if (fsm_q == StNode && conns_q != '0) begin
              fsm_d        = StConn;
              ctr_cnt_load = 1'b1;
              ctr_cnt_val  = conns_q;
            end else begin
              fsm_d = StEnd;
            end
          end
        end
      end
      StEnd: begin
        // Let the final read's data drain, then show end-of-genome for one cycle.
        if (phase_q == ST_END) begin
          fsm_d = StIdle;
        end else if (!rd_en_q) begin
          phase_d = ST_END;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= StIdle;
      conns_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_q     <= ST_IDLE;
      phase_q   <= ST_IDLE;
    end else begin
      fsm_q     <= fsm_d;
      conns_q   <= conns_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tag_q     <= tag_d;
      phase_q   <= phase_d;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = rd_addr_q;
  assign state     = phase_q;
  assign busy      = (fsm_q != StIdle);
  assign gene_out  = is_gene_phase(phase_q) ? mem_rd_data : '0;

endmodule
